ping_pong_buffer: RTL and testbench

- Double-buffered (ping-pong) 8-bit frame store between a streaming pixel/feature producer and the convolution engine.
- The producer writes sequentially into one bank while the convolution engine randomly reads the other bank by address.
- `i_switch_pingpong` swaps bank roles once per frame.
- `o_pl_buffer_ready` flags that the current write bank holds a complete frame.

---
 rtl/ping_pong_buffer_pkg.sv | 9 +
 rtl/ping_pong_buffer_bank_ram.sv | 25 ++
 rtl/ping_pong_buffer.sv | 78 +++++++
 tb/tb_ping_pong_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_buffer_pkg.sv
// Shared sizing for the ping-pong frame store.
// DATA_W sample width, ADDR_W bank address width, DEPTH samples per bank.
package ping_pong_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

endpackage

// File: rtl/ping_pong_buffer_bank_ram.sv
// One DEPTH x DATA_W bank: a write port and a registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read enable/address), rdata.
module pp_bank_ram
  import ping_pong_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the read register, so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ping_pong_buffer.sv
// Double-buffered frame store: producer fills one bank, conv engine reads the other.
// Ports: i_clk, i_rst, en, i_switch_pingpong, i_data_din(_vld), i_conv_addr, o_conv_dout, o_pl_buffer_ready.
module ping_pong_buffer
  import ping_pong_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              en,
  input  logic              i_switch_pingpong,
  input  logic [DATA_W-1:0] i_data_din,
  input  logic              i_data_din_vld,
  input  logic [ADDR_W-1:0] i_conv_addr,
  output logic [DATA_W-1:0] o_conv_dout,
  output logic              o_pl_buffer_ready
);

  logic              sel;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   wr_base;
  logic [ADDR_W:0]   wr_next;
  logic              bsel;
  logic              sw_evt;
  logic              can_wr;
  logic              rd_sel;
  logic              rd_vld;
  logic [DATA_W-1:0] dout_a;
  logic [DATA_W-1:0] dout_b;

  assign bsel   = i_switch_pingpong;
  assign sw_evt = bsel != sel;

  // A switch restarts the fill in the same cycle it is seen.
  assign wr_base = sw_evt ? '0 : wr_addr;
  assign can_wr  = en & i_data_din_vld & ~wr_base[ADDR_W];
  assign wr_next = wr_base + {{ADDR_W{1'b0}}, can_wr};

  pp_bank_ram u_bank_a (
    .clk   (i_clk),
    .we    (can_wr & ~bsel),
    .waddr (wr_base[ADDR_W-1:0]),
    .wdata (i_data_din),
    .re    (en & bsel),
    .raddr (i_conv_addr),
    .rdata (dout_a)
  );

  pp_bank_ram u_bank_b (
    .clk   (i_clk),
    .we    (can_wr & bsel),
    .waddr (wr_base[ADDR_W-1:0]),
    .wdata (i_data_din),
    .re    (en & ~bsel),
    .raddr (i_conv_addr),
    .rdata (dout_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel               <= 1'b0;
      wr_addr           <= '0;
      o_pl_buffer_ready <= 1'b0;
      rd_sel            <= 1'b0;
      rd_vld            <= 1'b0;
    end else if (en) begin
      sel               <= bsel;
      wr_addr           <= wr_next;
      // Full exactly when the fill pointer reaches DEPTH.
      o_pl_buffer_ready <= wr_next[ADDR_W];
      rd_sel            <= bsel;
      rd_vld            <= 1'b1;
    end
  end

  // rd_vld masks the unreset RAM read registers until the first read.
  assign o_conv_dout = !rd_vld ? '0 :
                       rd_sel  ? dout_a : dout_b;

endmodule

// File: tb/tb_ping_pong_buffer.sv
// Testbench for ping_pong_buffer: table vectors, hand sequences, random traffic.
// All expectations come from a frame-level model of the two banks.
module tb_ping_pong_buffer;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sw;
  logic [DW-1:0] din;
  logic          vld;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          rdy;

  int total = 0;
  int bad   = 0;

  ping_pong_buffer dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .en                (en),
    .i_switch_pingpong (sw),
    .i_data_din        (din),
    .i_data_din_vld    (vld),
    .i_conv_addr       (addr),
    .o_conv_dout       (dout),
    .o_pl_buffer_ready (rdy)
  );

  always #5 clk = ~clk;

  // Model: frame roles, fill count, bank contents with known flags.
  logic [DW-1:0] mem [2][DP];
  bit            wrt [2][DP];
  bit            m_role;
  int            m_cnt;
  bit            m_rdy;
  logic [DW-1:0] m_dout;
  bit            m_known;

  task automatic model_step();
    int wb;
    int rb;
    if (rst) begin
      m_role  = 1'b0;
      m_cnt   = 0;
      m_rdy   = 1'b0;
      m_dout  = '0;
      m_known = 1'b1;
    end else if (en) begin
      if (sw != m_role) begin
        m_role = sw;
        m_cnt  = 0;
        m_rdy  = 1'b0;
      end
      wb = sw ? 1 : 0;
      rb = sw ? 0 : 1;
      m_dout  = mem[rb][addr];
      m_known = wrt[rb][addr];
      if (vld && m_cnt < DP) begin
        mem[wb][m_cnt] = din;
        wrt[wb][m_cnt] = 1'b1;
        m_cnt++;
        if (m_cnt == DP)
          m_rdy = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    total++;
    if (rdy !== m_rdy) begin
      bad++;
      $display("FAIL %s ready got=%0b want=%0b t=%0t", tag, rdy, m_rdy, $time);
    end
    if (m_known) begin
      total++;
      if (dout !== m_dout) begin
        bad++;
        $display("FAIL %s dout got=%0d want=%0d t=%0t", tag, dout, m_dout, $time);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic check_const(input string tag, input bit er,
                             input logic [DW-1:0] ed, input bit cd);
    total++;
    if (rdy !== er) begin
      bad++;
      $display("FAIL %s ready got=%0b want=%0b", tag, rdy, er);
    end
    if (cd) begin
      total++;
      if (dout !== ed) begin
        bad++;
        $display("FAIL %s dout got=%0d want=%0d", tag, dout, ed);
      end
    end
  endtask

  typedef struct {
    string         tag;
    bit            rst;
    bit            en;
    bit            sw;
    logic [DW-1:0] din;
    bit            vld;
    logic [AW-1:0] addr;
    int            n;
    bit            exp_rdy;
    logic [DW-1:0] exp_dout;
    bit            chk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string tag, bit r, bit e, bit s,
                              logic [DW-1:0] d, bit v, logic [AW-1:0] a,
                              int n, bit er, logic [DW-1:0] ed, bit c);
    vec_t x;
    x.tag = tag; x.rst = r; x.en = e; x.sw = s; x.din = d; x.vld = v;
    x.addr = a; x.n = n; x.exp_rdy = er; x.exp_dout = ed; x.chk = c;
    tbl.push_back(x);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; sw = 1'b0; din = '0; vld = 1'b0; addr = '0;

    add("reset",      1, 1, 0, 0, 0, 0,    10,   0, 0, 1);
    add("fill8_pre",  0, 1, 0, 8, 1, 0,    1023, 0, 0, 0);
    add("fill8_full", 0, 1, 0, 8, 1, 0,    1,    1, 0, 0);
    add("fill8_drop", 0, 1, 0, 8, 1, 0,    176,  1, 0, 0);
    add("sw1_first",  0, 1, 1, 7, 1, 0,    1,    0, 8, 1);
    add("fill7_pre",  0, 1, 1, 7, 1, 0,    1022, 0, 8, 1);
    add("fill7_full", 0, 1, 1, 7, 1, 0,    1,    1, 8, 1);
    add("sw0_a0",     0, 1, 0, 6, 1, 0,    1,    0, 7, 1);
    add("sw0_a1023",  0, 1, 0, 6, 1, 1023, 1,    0, 7, 1);
    add("fill6_pre",  0, 1, 0, 6, 1, 1023, 1021, 0, 7, 1);
    add("fill6_full", 0, 1, 0, 6, 1, 1023, 1,    1, 7, 1);
    add("sw1_d5",     0, 1, 1, 5, 1, 5,    1,    0, 6, 1);
    add("fill5_half", 0, 1, 1, 5, 1, 5,    499,  0, 6, 1);
    add("mid_rst",    1, 1, 1, 5, 1, 5,    3,    0, 0, 1);
    add("refill8",    0, 1, 0, 8, 1, 600,  1023, 0, 7, 1);
    add("refill8_f",  0, 1, 0, 8, 1, 0,    1,    1, 5, 1);
    add("re_sw1",     0, 1, 1, 7, 1, 0,    1,    0, 8, 1);
    add("re_fill7",   0, 1, 1, 7, 1, 0,    1023, 1, 8, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; sw = tbl[i].sw;
      din = tbl[i].din; vld = tbl[i].vld; addr = tbl[i].addr;
      for (int k = 0; k < tbl[i].n; k++)
        tick(tbl[i].tag);
      check_const(tbl[i].tag, tbl[i].exp_rdy, tbl[i].exp_dout, tbl[i].chk);
    end

    // Enable low: toggle the switch and strobe writes; everything holds.
    en = 1'b0; vld = 1'b1; din = 9; addr = 3;
    for (int k = 0; k < 20; k++) begin
      sw = k[0];
      tick("frozen");
      check_const("frozen", 1'b1, 8'd8, 1'b1);
    end
    // First enabled cycle takes the switch event (sel was 1).
    en = 1'b1; sw = 1'b0;
    tick("wake_sw");
    check_const("wake_sw", 1'b0, 8'd7, 1'b1);
    // Exactly 1023 more writes of 9 complete the frame.
    for (int k = 0; k < 1022; k++)
      tick("wake_fill");
    check_const("wake_pre", 1'b0, 8'd7, 1'b1);
    tick("wake_fill");
    check_const("wake_full", 1'b1, 8'd7, 1'b1);
    // Read latency: new address shows only after the edge.
    sw = 1'b1; addr = 10;
    tick("lat_a");
    check_const("lat_a", 1'b0, 8'd9, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 6000; k++) begin
      rst  = ($urandom_range(0, 999) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1499) == 0)
        sw = ~sw;
      vld  = ($urandom_range(0, 3) != 0);
      din  = DW'($urandom);
      addr = AW'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
